load_store_unit: RTL and testbench

Data-memory access stage of the core pipeline: it accepts one load or store request from the execute stage (address already computed, funct3 and destination register attached), drives a single-outstanding req/ack data-memory bus with byte enables, and returns sign- or zero-extended load data as a register writeback. It sits between the ALU output register and the data memory, feeding the register-file write port.

---
 rtl/load_store_unit.sv | 215 +++++++++++++++++++++
 tb/tb_load_store_unit.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/load_store_unit.sv
// Data-memory load/store stage: one outstanding req/ack access with lane placement and extension.
// Optional LSU_MISALIGN_TRAP_EN rejects misaligned halfword/word accesses with error code 01.
module load_store_unit #(
  parameter int unsigned pDataWidth = 32,
  parameter int unsigned pTimeout   = 255
) (
  input  logic                  iClk,
  input  logic                  iRst,
  input  logic                  iReqValid,
  input  logic                  iReqRead,
  input  logic                  iReqWrite,
  input  logic [pDataWidth-1:0] iReqAddr,
  input  logic [pDataWidth-1:0] iReqData,
  input  logic [2:0]            iReqFunct3,
  input  logic [4:0]            iReqRdAddr,
  output logic                  oBusy,
  output logic                  oMemReq,
  output logic                  oMemWe,
  output logic [pDataWidth-1:0] oMemAddr,
  output logic [pDataWidth-1:0] oMemWdata,
  output logic [3:0]            oMemBe,
  input  logic                  iMemAck,
  input  logic [pDataWidth-1:0] iMemRdata,
  output logic                  oWbDv,
  output logic [4:0]            oWbAddr,
  output logic [pDataWidth-1:0] oWbData,
  output logic                  oErr,
  output logic [1:0]            oErrCode
);

  localparam int unsigned CntW = $clog2(pTimeout + 1);

  typedef enum logic [0:0] {StIdle, StAccess} stateE;

  stateE                 stateQ, stateD;
  logic [CntW-1:0]       cntQ, cntD;
  logic                  memWeQ, memWeD;
  logic [pDataWidth-1:0] memAddrQ, memAddrD;
  logic [pDataWidth-1:0] memWdataQ, memWdataD;
  logic [3:0]            memBeQ, memBeD;
  logic [4:0]            rdQ, rdD;
  logic [2:0]            funct3Q, funct3D;
  logic [1:0]            laneQ, laneD;
  logic                  wbDvQ, wbDvD;
  logic [4:0]            wbAddrQ, wbAddrD;
  logic [pDataWidth-1:0] wbDataQ, wbDataD;
  logic                  errQ, errD;
  logic [1:0]            errCodeQ, errCodeD;

  logic                  illegal;
  logic                  misaligned;
  logic [pDataWidth-1:0] placedData;
  logic [3:0]            placedBe;
  logic [pDataWidth-1:0] shifted;
  logic [pDataWidth-1:0] loadExt;

  always_comb begin
    illegal = 1'b0;
    if (iReqRead == iReqWrite) begin
      illegal = 1'b1;
    end else if (iReqRead) begin
      illegal = !(iReqFunct3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101});
    end else begin
      illegal = !(iReqFunct3 inside {3'b000, 3'b001, 3'b010});
    end
  end

`ifdef LSU_MISALIGN_TRAP_EN
  assign misaligned = ((iReqFunct3[1:0] == 2'b01) && iReqAddr[0]) ||
                      ((iReqFunct3[1:0] == 2'b10) && (iReqAddr[1:0] != 2'b00));
`else
  assign misaligned = 1'b0;
`endif

  // Halfwords select their lane with addr[1] only, so a trapped build and an untrapped one agree
  // on every aligned access.
  always_comb begin
    placedData = '0;
    placedBe   = 4'b1111;
    if (iReqWrite) begin
      case (iReqFunct3[1:0])
        2'b00: begin
          placedBe   = 4'b0001 << iReqAddr[1:0];
          placedData = {24'b0, iReqData[7:0]} << {iReqAddr[1:0], 3'b000};
        end
        2'b01: begin
          placedBe   = 4'b0011 << {iReqAddr[1], 1'b0};
          placedData = {16'b0, iReqData[15:0]} << {iReqAddr[1], 4'b0000};
        end
        default: placedData = iReqData;
      endcase
    end
  end

  always_comb begin
    shifted = iMemRdata;
    case (funct3Q[1:0])
      2'b00:   shifted = iMemRdata >> {laneQ, 3'b000};
      2'b01:   shifted = iMemRdata >> {laneQ[1], 4'b0000};
      default: shifted = iMemRdata;
    endcase
    case (funct3Q)
      3'b000:  loadExt = {{24{shifted[7]}}, shifted[7:0]};
      3'b001:  loadExt = {{16{shifted[15]}}, shifted[15:0]};
      3'b100:  loadExt = {24'b0, shifted[7:0]};
      3'b101:  loadExt = {16'b0, shifted[15:0]};
      default: loadExt = shifted;
    endcase
  end

  always_comb begin
    stateD    = stateQ;
    cntD      = cntQ;
    memWeD    = memWeQ;
    memAddrD  = memAddrQ;
    memWdataD = memWdataQ;
    memBeD    = memBeQ;
    rdD       = rdQ;
    funct3D   = funct3Q;
    laneD     = laneQ;
    wbDvD     = 1'b0;
    wbAddrD   = wbAddrQ;
    wbDataD   = wbDataQ;
    errD      = 1'b0;
    errCodeD  = errCodeQ;
    unique case (stateQ)
      StIdle: begin
        cntD = '0;
        if (iReqValid) begin
          if (illegal) begin
            errD     = 1'b1;
            errCodeD = 2'b11;
          end else if (misaligned) begin
            errD     = 1'b1;
            errCodeD = 2'b01;
          end else begin
            memWeD    = iReqWrite;
            memAddrD  = {iReqAddr[pDataWidth-1:2], 2'b00};
            memWdataD = placedData;
            memBeD    = placedBe;
            rdD       = iReqRdAddr;
            funct3D   = iReqFunct3;
            laneD     = iReqAddr[1:0];
            stateD    = StAccess;
          end
        end
      end
      StAccess: begin
        // An ack in the final wait cycle takes priority over the timeout.
        if (iMemAck) begin
          stateD = StIdle;
          if (!memWeQ && (rdQ != 5'd0)) begin
            wbDvD   = 1'b1;
            wbAddrD = rdQ;
            wbDataD = loadExt;
          end
        end else if (cntQ == CntW'(pTimeout - 1)) begin
          stateD   = StIdle;
          errD     = 1'b1;
          errCodeD = 2'b10;
        end else begin
          cntD = cntQ + CntW'(1);
        end
      end
      default: stateD = StIdle;
    endcase
  end

  always_ff @(posedge iClk or posedge iRst) begin
    if (iRst) begin
      stateQ    <= StIdle;
      cntQ      <= '0;
      memWeQ    <= 1'b0;
      memAddrQ  <= '0;
      memWdataQ <= '0;
      memBeQ    <= 4'b0000;
      rdQ       <= 5'd0;
      funct3Q   <= 3'b000;
      laneQ     <= 2'b00;
      wbDvQ     <= 1'b0;
      wbAddrQ   <= 5'd0;
      wbDataQ   <= '0;
      errQ      <= 1'b0;
      errCodeQ  <= 2'b00;
    end else begin
      stateQ    <= stateD;
      cntQ      <= cntD;
      memWeQ    <= memWeD;
      memAddrQ  <= memAddrD;
      memWdataQ <= memWdataD;
      memBeQ    <= memBeD;
      rdQ       <= rdD;
      funct3Q   <= funct3D;
      laneQ     <= laneD;
      wbDvQ     <= wbDvD;
      wbAddrQ   <= wbAddrD;
      wbDataQ   <= wbDataD;
      errQ      <= errD;
      errCodeQ  <= errCodeD;
    end
  end

  assign oBusy     = (stateQ == StAccess);
  assign oMemReq   = (stateQ == StAccess);
  assign oMemWe    = memWeQ;
  assign oMemAddr  = memAddrQ;
  assign oMemWdata = memWdataQ;
  assign oMemBe    = memBeQ;
  assign oWbDv     = wbDvQ;
  assign oWbAddr   = wbAddrQ;
  assign oWbData   = wbDataQ;
  assign oErr      = errQ;
  assign oErrCode  = errCodeQ;

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit: lane placement, extension, timeout, errors and reset.
module tb_load_store_unit;

  logic        iClk = 1'b0;
  logic        iRst;
  logic        iReqValid, iReqRead, iReqWrite;
  logic [31:0] iReqAddr, iReqData;
  logic [2:0]  iReqFunct3;
  logic [4:0]  iReqRdAddr;
  logic        oBusy, oMemReq, oMemWe;
  logic [31:0] oMemAddr, oMemWdata;
  logic [3:0]  oMemBe;
  logic        iMemAck;
  logic [31:0] iMemRdata;
  logic        oWbDv;
  logic [4:0]  oWbAddr;
  logic [31:0] oWbData;
  logic        oErr;
  logic [1:0]  oErrCode;

  int total = 0;
  int bad   = 0;

  load_store_unit #(.pDataWidth(32), .pTimeout(4)) dut (
    .iClk(iClk), .iRst(iRst),
    .iReqValid(iReqValid), .iReqRead(iReqRead), .iReqWrite(iReqWrite),
    .iReqAddr(iReqAddr), .iReqData(iReqData), .iReqFunct3(iReqFunct3),
    .iReqRdAddr(iReqRdAddr),
    .oBusy(oBusy), .oMemReq(oMemReq), .oMemWe(oMemWe), .oMemAddr(oMemAddr),
    .oMemWdata(oMemWdata), .oMemBe(oMemBe), .iMemAck(iMemAck), .iMemRdata(iMemRdata),
    .oWbDv(oWbDv), .oWbAddr(oWbAddr), .oWbData(oWbData),
    .oErr(oErr), .oErrCode(oErrCode)
  );

  always #5 iClk = ~iClk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Advance to 1 time unit after the next rising edge: outputs are settled, inputs may change.
  task automatic step();
    @(posedge iClk);
    #1;
  endtask

  task automatic req(input logic rd, input logic wr, input logic [31:0] addr,
                     input logic [31:0] data, input logic [2:0] f3, input logic [4:0] rdAddr);
    iReqValid  = 1'b1;
    iReqRead   = rd;
    iReqWrite  = wr;
    iReqAddr   = addr;
    iReqData   = data;
    iReqFunct3 = f3;
    iReqRdAddr = rdAddr;
  endtask

  task automatic noReq();
    iReqValid = 1'b0;
    iReqRead  = 1'b0;
    iReqWrite = 1'b0;
  endtask

  initial begin
    iRst = 1'b1;
    noReq();
    iReqAddr = '0; iReqData = '0; iReqFunct3 = '0; iReqRdAddr = '0;
    iMemAck = 1'b0; iMemRdata = '0;
    step();
    check("rst_busy", {31'b0, oBusy}, 32'd0);
    check("rst_memreq", {31'b0, oMemReq}, 32'd0);
    check("rst_addr", oMemAddr, 32'd0);
    check("rst_be", {28'b0, oMemBe}, 32'd0);
    check("rst_wb", {31'b0, oWbDv}, 32'd0);
    check("rst_err", {29'b0, oErr, oErrCode}, 32'd0);
    iRst = 1'b0;
    step();

    // LB 0x103, ack in cycle 3, rd=5
    req(1, 0, 32'h103, 32'h0, 3'b000, 5'd5);
    step(); noReq();
    check("lb_c1_req", {30'b0, oMemReq, oBusy}, 32'd3);
    check("lb_addr", oMemAddr, 32'h100);
    check("lb_be", {27'b0, oMemWe, oMemBe}, 32'h0F);
    step();
    check("lb_c2_req", {31'b0, oMemReq}, 32'd1);
    step();
    iMemAck = 1'b1; iMemRdata = 32'h80FF_1234;
    step(); iMemAck = 1'b0;
    check("lb_c4_wbdv", {30'b0, oWbDv, oBusy}, 32'd2);
    check("lb_wbaddr", {27'b0, oWbAddr}, 32'd5);
    check("lb_wbdata", oWbData, 32'hFFFF_FF80);
    step();
    check("lb_c5_wbdv", {31'b0, oWbDv}, 32'd0);

    // LBU same stimulus
    req(1, 0, 32'h103, 32'h0, 3'b100, 5'd5);
    step(); noReq();
    step(); step();
    iMemAck = 1'b1;
    step(); iMemAck = 1'b0;
    check("lbu_wbdv", {31'b0, oWbDv}, 32'd1);
    check("lbu_wbdata", oWbData, 32'h0000_0080);
    step();

    // SH 0x42 data 0xBEEF, ack in cycle 1
    req(0, 1, 32'h42, 32'h0000_BEEF, 3'b001, 5'd0);
    step(); noReq();
    check("sh_we_be", {27'b0, oMemWe, oMemBe}, 32'h1C);
    check("sh_wdata", oMemWdata, 32'hBEEF_0000);
    check("sh_addr", oMemAddr, 32'h40);
    iMemAck = 1'b1;
    step(); iMemAck = 1'b0;
    check("sh_c2", {29'b0, oBusy, oMemReq, oWbDv}, 32'd0);

    // SB lane 1
    req(0, 1, 32'h81, 32'h1234_56A5, 3'b000, 5'd0);
    step(); noReq();
    check("sb_be", {28'b0, oMemBe}, 32'h2);
    check("sb_wdata", oMemWdata, 32'h0000_A500);
    iMemAck = 1'b1;
    step(); iMemAck = 1'b0;

    // LH 0x102 sign-extends upper half
    req(1, 0, 32'h102, 32'h0, 3'b001, 5'd6);
    step(); noReq();
    iMemAck = 1'b1; iMemRdata = 32'h8001_1234;
    step(); iMemAck = 1'b0;
    check("lh_wbdata", oWbData, 32'hFFFF_8001);

    // Back-to-back LW: second request presented in cycle 2
    req(1, 0, 32'h200, 32'h0, 3'b010, 5'd7);
    step(); noReq();
    iMemAck = 1'b1; iMemRdata = 32'h1234_5678;
    step(); iMemAck = 1'b0;
    check("b2b_wb1", {31'b0, oWbDv}, 32'd1);
    check("b2b_wbdata1", oWbData, 32'h1234_5678);
    req(1, 0, 32'h204, 32'h0, 3'b010, 5'd8);
    step(); noReq();
    check("b2b_req2", {31'b0, oMemReq}, 32'd1);
    check("b2b_addr2", oMemAddr, 32'h204);
    iMemAck = 1'b1; iMemRdata = 32'hCAFE_F00D;
    step(); iMemAck = 1'b0;
    check("b2b_wb2", {27'b0, oWbAddr}, 32'd8);
    check("b2b_wbdata2", oWbData, 32'hCAFE_F00D);

    // Timeout with pTimeout=4
    req(1, 0, 32'h300, 32'h0, 3'b010, 5'd3);
    for (int c = 1; c <= 4; c++) begin
      step(); noReq();
      check($sformatf("to_req_c%0d", c), {30'b0, oMemReq, oErr}, 32'd2);
    end
    step();
    check("to_err", {29'b0, oErr, oErrCode}, 32'b110);
    check("to_idle", {29'b0, oBusy, oMemReq, oWbDv}, 32'd0);
    step();
    check("to_err_pulse", {31'b0, oErr}, 32'd0);

    // Ack in the final wait cycle beats the timeout
    req(1, 0, 32'h304, 32'h0, 3'b010, 5'd3);
    step(); noReq();
    step(); step(); step();
    iMemAck = 1'b1; iMemRdata = 32'h0BAD_CAFE;
    step(); iMemAck = 1'b0;
    check("ackwin", {30'b0, oWbDv, oErr}, 32'd2);
    check("ackwin_data", oWbData, 32'h0BAD_CAFE);

    // rd=0 load accesses memory but no writeback
    req(1, 0, 32'h10, 32'h0, 3'b010, 5'd0);
    step(); noReq();
    check("rd0_req", {31'b0, oMemReq}, 32'd1);
    iMemAck = 1'b1;
    step(); iMemAck = 1'b0;
    check("rd0_nowb", {30'b0, oWbDv, oBusy}, 32'd0);

    // LW at 0x102
    req(1, 0, 32'h102, 32'h0, 3'b010, 5'd9);
    step(); noReq();
`ifdef LSU_MISALIGN_TRAP_EN
    check("mis_err", {29'b0, oErr, oErrCode}, 32'b101);
    check("mis_noreq", {30'b0, oMemReq, oBusy}, 32'd0);
`else
    check("mis_req", {31'b0, oMemReq}, 32'd1);
    check("mis_addr", oMemAddr, 32'h100);
    iMemAck = 1'b1; iMemRdata = 32'h55AA_55AA;
    step(); iMemAck = 1'b0;
    check("mis_wbdata", oWbData, 32'h55AA_55AA);
`endif
    step();

    // Illegal requests, the second presented in the first error's cycle 1
    req(1, 1, 32'h0, 32'h0, 3'b010, 5'd1);
    step();
    check("ill_rw", {29'b0, oErr, oErrCode}, 32'b111);
    check("ill_rw_noreq", {30'b0, oMemReq, oBusy}, 32'd0);
    req(1, 0, 32'h0, 32'h0, 3'b011, 5'd1);
    step();
    check("ill_f3", {29'b0, oErr, oErrCode}, 32'b111);
    req(0, 0, 32'h0, 32'h0, 3'b000, 5'd1);
    step();
    check("ill_none", {29'b0, oErr, oErrCode}, 32'b111);
    req(0, 1, 32'h0, 32'h0, 3'b100, 5'd1);
    step(); noReq();
    check("ill_store_f3", {29'b0, oErr, oErrCode}, 32'b111);
    step();
    check("ill_clear", {30'b0, oErr, oMemReq}, 32'd0);

    // Ack while idle is ignored
    iMemAck = 1'b1;
    step(); iMemAck = 1'b0;
    check("idle_ack", {29'b0, oBusy, oWbDv, oErr}, 32'd0);

    // Reset during access
    req(1, 0, 32'h400, 32'h0, 3'b010, 5'd4);
    step(); noReq();
    check("rstm_req", {31'b0, oMemReq}, 32'd1);
    #2 iRst = 1'b1;
    #1;
    check("rstm_async", {29'b0, oBusy, oMemReq, oWbDv}, 32'd0);
    check("rstm_addr", oMemAddr, 32'd0);
    iMemAck = 1'b1;
    step();
    iRst = 1'b0;
    step(); iMemAck = 1'b0;
    check("rstm_nowb", {29'b0, oWbDv, oErr, oBusy}, 32'd0);
    step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
